// File: rtl/spi_reg_arbiter_if.sv
// rtl/spi_reg_arbiter_if.sv - requester bus and byte-engine FIFO port of spi_reg_arbiter
interface spi_reg_arbiter_if #(
  parameter int N_REQ = 2
) ();
  logic [N_REQ-1:0]   req;
  logic [N_REQ-1:0]   req_rw;
  logic [7*N_REQ-1:0] req_addr;
  logic [8*N_REQ-1:0] req_wdata;
  logic [N_REQ-1:0]   gnt;
  logic [N_REQ-1:0]   done;
  logic               err;
  logic [7:0]         rdata;
  logic               busy;
  logic [7:0]         master_data;
  logic               master_empty;
  logic               master_rdreq;
  logic [7:0]         miso_reg;
  logic               slave_wrreq;

  modport master (
    input  req, req_rw, req_addr, req_wdata, master_rdreq, miso_reg, slave_wrreq,
    output gnt, done, err, rdata, busy, master_data, master_empty
  );

  modport slave (
    output req, req_rw, req_addr, req_wdata, master_rdreq, miso_reg, slave_wrreq,
    input  gnt, done, err, rdata, busy, master_data, master_empty
  );
endinterface

// File: rtl/spi_reg_arbiter.sv
// rtl/spi_reg_arbiter.sv - round-robin register-access controller feeding spi_master_byte
module spi_reg_arbiter #(
  parameter int N_REQ   = 2,
  parameter int GUARD   = 2,
  parameter int TIMEOUT = 64
) (
  input  logic               sclk,
  input  logic               n_rst,
  spi_reg_arbiter_if.master  bus
);
  localparam int IW = $clog2(N_REQ);

  typedef enum logic [2:0] {IDLE, B0, B1, RX, FIN, GAP} state_t;

  state_t           state, state_nxt;
  logic [IW-1:0]    ptr, ptr_nxt, idx, idx_nxt, sel;
  logic             found;
  logic             rw, rw_nxt;
  logic [6:0]       addr, addr_nxt;
  logic [7:0]       wdata, wdata_nxt;
  logic [1:0]       scnt, scnt_nxt;
  logic [7:0]       tcnt, tcnt_nxt;
  logic [7:0]       rx_byte, rx_byte_nxt;
  logic             strobe_last, in_frame;
  logic [N_REQ-1:0] gnt_q, gnt_nxt, done_q, done_nxt;
  logic             err_q, err_nxt, busy_q, empty_q;
  logic [7:0]       rdata_q, rdata_nxt, mdata_q, mdata_nxt;

  // First requester at or after ptr, wrapping.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && bus.req[(int'(ptr) + k) % N_REQ]) begin
        found = 1'b1;
        sel   = IW'((int'(ptr) + k) % N_REQ);
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    idx_nxt     = idx;
    rw_nxt      = rw;
    addr_nxt    = addr;
    wdata_nxt   = wdata;
    scnt_nxt    = scnt;
    tcnt_nxt    = tcnt;
    rx_byte_nxt = rx_byte;
    rdata_nxt   = rdata_q;
    err_nxt     = 1'b0;
    gnt_nxt     = '0;
    done_nxt    = '0;
    in_frame    = (state == B0) || (state == B1) || (state == RX);
    strobe_last = in_frame && bus.slave_wrreq && (scnt == 2'd1);

    if (in_frame && bus.slave_wrreq && (scnt != 2'd3))
      scnt_nxt = scnt + 2'd1;
    if (strobe_last)
      rx_byte_nxt = bus.miso_reg;

    case (state)
      IDLE: if (found) begin
        state_nxt    = B0;
        idx_nxt      = sel;
        rw_nxt       = bus.req_rw[sel];
        addr_nxt     = bus.req_addr[7*sel +: 7];
        wdata_nxt    = bus.req_wdata[8*sel +: 8];
        gnt_nxt[sel] = 1'b1;
        ptr_nxt      = (sel == IW'(N_REQ - 1)) ? '0 : sel + 1'b1;
        scnt_nxt     = '0;
      end
      B0: if (bus.master_rdreq) state_nxt = B1;
      B1: if (bus.master_rdreq) begin
        state_nxt = RX;
        tcnt_nxt  = '0;
      end
      RX: begin
        // Second strobe has priority over a coincident timeout.
        if (scnt >= 2'd2 || strobe_last) begin
          state_nxt     = FIN;
          rdata_nxt     = strobe_last ? bus.miso_reg : rx_byte;
          done_nxt[idx] = 1'b1;
        end else if (tcnt >= 8'(TIMEOUT)) begin
          state_nxt     = FIN;
          err_nxt       = 1'b1;
          done_nxt[idx] = 1'b1;
        end else if (tcnt != 8'hFF) begin
          tcnt_nxt = tcnt + 8'd1;
        end
      end
      FIN: begin
        state_nxt = GAP;
        tcnt_nxt  = '0;
      end
      GAP: begin
        if (tcnt >= 8'(GUARD - 1)) state_nxt = IDLE;
        else                       tcnt_nxt  = tcnt + 8'd1;
      end
      default: state_nxt = IDLE;
    endcase

    mdata_nxt = (state_nxt == B0) ? {rw_nxt, addr_nxt} :
                (state_nxt == B1) ? (rw_nxt ? 8'h00 : wdata_nxt) : 8'h00;
  end

  always_ff @(posedge sclk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= IDLE;
      ptr     <= '0;
      idx     <= '0;
      rw      <= 1'b0;
      addr    <= '0;
      wdata   <= '0;
      scnt    <= '0;
      tcnt    <= '0;
      rx_byte <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      mdata_q <= '0;
      empty_q <= 1'b1;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      idx     <= idx_nxt;
      rw      <= rw_nxt;
      addr    <= addr_nxt;
      wdata   <= wdata_nxt;
      scnt    <= scnt_nxt;
      tcnt    <= tcnt_nxt;
      rx_byte <= rx_byte_nxt;
      gnt_q   <= gnt_nxt;
      done_q  <= done_nxt;
      err_q   <= err_nxt;
      rdata_q <= rdata_nxt;
      busy_q  <= (state_nxt != IDLE);
      mdata_q <= mdata_nxt;
      empty_q <= !((state_nxt == B0) || (state_nxt == B1));
    end
  end

  assign bus.gnt          = gnt_q;
  assign bus.done         = done_q;
  assign bus.err          = err_q;
  assign bus.rdata        = rdata_q;
  assign bus.busy         = busy_q;
  assign bus.master_data  = mdata_q;
  assign bus.master_empty = empty_q;
endmodule

// File: tb/tb_spi_reg_arbiter.sv
// tb/tb_spi_reg_arbiter.sv - directed self-checking bench for spi_reg_arbiter
module tb_spi_reg_arbiter;
  localparam int N_REQ   = 2;
  localparam int GUARD   = 2;
  localparam int TIMEOUT = 64;

  logic sclk  = 1'b0;
  logic n_rst = 1'b0;
  int   n_checks = 0;
  int   n_errs   = 0;
  int   n;
  int   spur;

  spi_reg_arbiter_if #(.N_REQ(N_REQ)) bus ();

  spi_reg_arbiter #(.N_REQ(N_REQ), .GUARD(GUARD), .TIMEOUT(TIMEOUT)) dut (
    .sclk  (sclk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 sclk = ~sclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic wait_gnt(output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (bus.gnt == '0 && cnt < 40);
  endtask

  // Called #1 after the gnt edge; plays the byte engine for one frame.
  task automatic engine(input logic [7:0] b0, input logic [7:0] b1,
                        input logic [7:0] rx0, input logic [7:0] rx1, input bit send2);
    check("b0_data", bus.master_data, b0);
    check("b0_empty", bus.master_empty, 0);
    bus.master_rdreq = 1'b1;
    tick();
    check("b1_data", bus.master_data, b1);
    check("b1_empty", bus.master_empty, 0);
    bus.slave_wrreq = 1'b1;
    bus.miso_reg    = rx0;
    tick();
    bus.master_rdreq = 1'b0;
    bus.slave_wrreq  = 1'b0;
    check("rx_empty", bus.master_empty, 1);
    check("rx_data", bus.master_data, 8'h00);
    if (send2) begin
      tick();
      tick();
      bus.slave_wrreq = 1'b1;
      bus.miso_reg    = rx1;
      tick();
      bus.slave_wrreq = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req = '0; bus.req_rw = '0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.master_rdreq = 1'b0; bus.miso_reg = '0; bus.slave_wrreq = 1'b0;
    repeat (3) tick();
    check("rst_gnt", bus.gnt, 0);
    check("rst_done", bus.done, 0);
    check("rst_err", bus.err, 0);
    check("rst_rdata", bus.rdata, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_mdata", bus.master_data, 0);
    check("rst_empty", bus.master_empty, 1);
    n_rst = 1'b1;
    tick();

    // Write from requester 0
    bus.req_rw = 2'b00; bus.req_addr = {7'h00, 7'h15}; bus.req_wdata = {8'h00, 8'hA5};
    bus.req = 2'b01;
    wait_gnt(n);
    check("w_gnt", bus.gnt, 2'b01);
    check("w_gnt_lat", n, 1);
    check("w_busy", bus.busy, 1);
    bus.req = 2'b00;
    engine(8'h15, 8'hA5, 8'h11, 8'h22, 1'b1);
    check("w_done", bus.done, 2'b01);
    check("w_err", bus.err, 0);
    check("w_rdata", bus.rdata, 8'h22);
    repeat (5) tick();
    check("w_idle_busy", bus.busy, 0);

    // Read from requester 1
    bus.req_rw = 2'b10; bus.req_addr = {7'h02, 7'h00}; bus.req_wdata = '0;
    bus.req = 2'b10;
    wait_gnt(n);
    check("r_gnt", bus.gnt, 2'b10);
    bus.req = 2'b00;
    engine(8'h82, 8'h00, 8'h00, 8'h3C, 1'b1);
    check("r_done", bus.done, 2'b10);
    check("r_err", bus.err, 0);
    check("r_rdata", bus.rdata, 8'h3C);
    tick();
    check("r_done_pulse", bus.done, 0);
    check("r_rdata_hold", bus.rdata, 8'h3C);
    repeat (6) tick();

    // Both requesting: round-robin 0,1,0 with minimum spacing
    bus.req_rw = 2'b00; bus.req_addr = {7'h0A, 7'h05}; bus.req_wdata = {8'hBB, 8'hAA};
    bus.req = 2'b11;
    for (int t = 0; t < 3; t++) begin
      wait_gnt(n);
      check("rr_gnt", bus.gnt, (t % 2 == 0) ? 2'b01 : 2'b10);
      check("rr_spacing", n, (t == 0) ? 1 : GUARD + 2);
      if (t == 2) bus.req = 2'b00;
      engine((t % 2 == 0) ? 8'h05 : 8'h0A, (t % 2 == 0) ? 8'hAA : 8'hBB, 8'h00, 8'h5A, 1'b1);
      check("rr_done", bus.done, (t % 2 == 0) ? 2'b01 : 2'b10);
    end
    repeat (6) tick();

    // Engine never sends the second strobe
    bus.req_addr = {7'h33, 7'h00}; bus.req_wdata = {8'h44, 8'h00};
    bus.req = 2'b10;
    wait_gnt(n);
    check("to_gnt", bus.gnt, 2'b10);
    bus.req = 2'b00;
    engine(8'h33, 8'h44, 8'h55, 8'h00, 1'b0);
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.done == '0 && n < 200);
    check("to_cycles", n, TIMEOUT + 1);
    check("to_done", bus.done, 2'b10);
    check("to_err", bus.err, 1);
    check("to_rdata", bus.rdata, 8'h5A);
    repeat (6) tick();

    // Reset asserted while in B1
    bus.req_addr = {7'h00, 7'h21}; bus.req_wdata = {8'h00, 8'h77};
    bus.req = 2'b01;
    wait_gnt(n);
    check("rb_gnt", bus.gnt, 2'b01);
    bus.req = 2'b00;
    bus.master_rdreq = 1'b1;
    tick();
    bus.master_rdreq = 1'b0;
    check("rb_b1_data", bus.master_data, 8'h77);
    n_rst = 1'b0;
    #1;
    check("rb_mdata", bus.master_data, 0);
    check("rb_empty", bus.master_empty, 1);
    check("rb_busy", bus.busy, 0);
    check("rb_rdata", bus.rdata, 0);
    tick();
    check("rb_done", bus.done, 0);
    check("rb_err", bus.err, 0);
    n_rst = 1'b1;
    tick();
    bus.req = 2'b11;
    wait_gnt(n);
    check("rb_regnt", bus.gnt, 2'b01);
    bus.req = 2'b00;
    engine(8'h21, 8'h77, 8'h00, 8'h66, 1'b1);
    check("rb_redone", bus.done, 2'b01);

    // One-cycle request pulse while busy is never serviced
    bus.req = 2'b01;
    check("pl_busy", bus.busy, 1);
    tick();
    bus.req = 2'b00;
    spur = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.gnt != '0 || bus.done != '0) spur++;
    end
    check("pl_spurious", spur, 0);
    check("pl_idle", bus.busy, 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
